// File: rtl/out_bank_serializer_pkg.sv
// Shared constants and types for the output bank serializer.
// Channel count is fixed; enable and index widths follow from it.
package out_bank_serializer_pkg;

   localparam int NCH  = 32;
   localparam int CH_W = 5;

   // The controller encodes a slot-31 write as all enables set.
   localparam logic [NCH-1:0] ENABLE_ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   // Turns a controller enable word into the set of slots written.
   function automatic logic [NCH-1:0] decode_enable(
      input logic [NCH-1:0] en
   );
      logic [NCH-1:0] wr;
      wr = en;
      if (en == ENABLE_ALL_ONES) begin
         wr = '0;
         wr[NCH-1] = 1'b1;
      end
      return wr;
   endfunction

endpackage

// File: rtl/out_bank_serializer_bank_regfile.sv
// Capture bank for the per-channel results, with a combinational
// view that already includes this cycle's writes for the commit.
module out_bank_serializer_bank_regfile
   import out_bank_serializer_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DW-1:0]            sum,
   input  logic [NCH-1:0]           en,
   output logic [NCH-1:0][DW-1:0]   fwd
);

   logic [NCH-1:0]          wr;
   logic [NCH-1:0][DW-1:0]  cap;

   // Slot write mask after the all-ones special case.
   always_comb begin
      wr = decode_enable(en);
   end

   // Capture bank: flagged slots take sum, others hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (wr[i]) begin
               cap[i] <= sum;
            end
         end
      end
   end

   // Forward path so a commit sees a same-cycle slot write.
   always_comb begin
      fwd = cap;
      for (int i = 0; i < NCH; i++) begin
         if (wr[i]) begin
            fwd[i] = sum;
         end
      end
   end

endmodule

// File: rtl/out_bank_serializer.sv
// Double-buffered result bank: capture under controller enables,
// commit to a shadow bank on frame-done, drain over valid/ready.
module out_bank_serializer
   import out_bank_serializer_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic             clk,
   input  logic             GlobalReset,
   input  logic [DW-1:0]    sum_in,
   input  logic [NCH-1:0]   enableRegControl,
   input  logic             srdyi,
   input  logic             drdy,
   output logic [DW-1:0]    dout,
   output logic [CH_W-1:0]  ch_out,
   output logic             dvalid,
   output logic             busy,
   output logic             ovf,
   output logic [7:0]       frame_cnt
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

   state_t                  state;
   logic [NCH-1:0][DW-1:0]  shadow;
   logic [NCH-1:0][DW-1:0]  fwd;
   logic [CH_W-1:0]         nxt;
   logic                    last;

   out_bank_serializer_bank_regfile #(
      .DW (DW)
   ) u_bank (
      .clk   (clk),
      .rst_n (GlobalReset),
      .sum   (sum_in),
      .en    (enableRegControl),
      .fwd   (fwd)
   );

   // Next drain index and the final-beat transfer condition.
   always_comb begin
      nxt  = ch_out + CH_W'(1);
      last = (state == STREAM) && drdy && (ch_out == LAST_CH);
   end

   // Commit/drain FSM with registered stream outputs.
   always_ff @(posedge clk) begin
      if (!GlobalReset) begin
         state     <= IDLE;
         shadow    <= '0;
         dout      <= '0;
         ch_out    <= '0;
         dvalid    <= 1'b0;
         busy      <= 1'b0;
         ovf       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (srdyi) begin
                  shadow <= fwd;
                  dout   <= fwd[0];
                  ch_out <= '0;
                  dvalid <= 1'b1;
                  busy   <= 1'b1;
                  state  <= STREAM;
               end
            end
            STREAM: begin
               // A commit is only accepted on the final transfer.
               if (srdyi && !last) begin
                  ovf <= 1'b1;
               end
               if (drdy) begin
                  if (ch_out == LAST_CH) begin
                     frame_cnt <= frame_cnt + 8'd1;
                     ch_out    <= '0;
                     if (srdyi) begin
                        shadow <= fwd;
                        dout   <= fwd[0];
                     end else begin
                        dvalid <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                     end
                  end else begin
                     ch_out <= nxt;
                     dout   <= shadow[nxt];
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out_bank_serializer.sv
// Directed bench with a beat scoreboard for out_bank_serializer.
// Expected beats are queued at commit and popped on each transfer.
module tb_out_bank_serializer;

   typedef struct packed {
      logic [4:0]  ch;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        GlobalReset = 1'b0;
   logic [31:0] sum_in = '0;
   logic [31:0] enableRegControl = '0;
   logic        srdyi = 1'b0;
   logic        drdy = 1'b0;
   logic [31:0] dout;
   logic [4:0]  ch_out;
   logic        dvalid;
   logic        busy;
   logic        ovf;
   logic [7:0]  frame_cnt;

   int          checks = 0;
   int          failures = 0;
   beat_t       q[$];
   logic [31:0] mcap[32];
   int          mfc = 0;
   logic        prev_stall = 1'b0;
   logic [4:0]  prev_ch = '0;
   logic [31:0] prev_dout = '0;
   logic        busy_drop;

   out_bank_serializer #(
      .DW (32)
   ) dut (
      .clk              (clk),
      .GlobalReset      (GlobalReset),
      .sum_in           (sum_in),
      .enableRegControl (enableRegControl),
      .srdyi            (srdyi),
      .drdy             (drdy),
      .dout             (dout),
      .ch_out           (ch_out),
      .dvalid           (dvalid),
      .busy             (busy),
      .ovf              (ovf),
      .frame_cnt        (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model of the capture write decode.
   task automatic model_write(input logic [31:0] e, input logic [31:0] s);
      if (e == 32'hFFFF_FFFF) begin
         mcap[31] = s;
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (e[i]) mcap[i] = s;
         end
      end
   endtask

   task automatic write_slot(input int i, input logic [31:0] s);
      logic [31:0] e;
      e = (i == 31) ? 32'hFFFF_FFFF : (32'd1 << i);
      enableRegControl = e;
      sum_in = s;
      model_write(e, s);
      tick();
      enableRegControl = '0;
   endtask

   task automatic load_frame(input logic [31:0] base);
      for (int i = 0; i < 32; i++) begin
         write_slot(i, base + 32'(i));
      end
   endtask

   // Pulse srdyi with an optional same-cycle write; queue the frame.
   task automatic commit(input logic [31:0] e, input logic [31:0] s);
      beat_t b;
      model_write(e, s);
      for (int i = 0; i < 32; i++) begin
         b.ch = 5'(i);
         b.data = mcap[i];
         q.push_back(b);
      end
      enableRegControl = e;
      sum_in = s;
      srdyi = 1'b1;
      tick();
      srdyi = 1'b0;
      enableRegControl = '0;
   endtask

   // Drain with drdy high (mode 0) or pattern 1,0,0 (mode 1).
   task automatic wait_drain(input int mode, input int exp_x,
                             input string tag);
      int xfers;
      int k;
      xfers = 0;
      k = 0;
      while (k < 400 && (dvalid || q.size() != 0)) begin
         drdy = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         if (dvalid && drdy) xfers++;
         tick();
         k++;
      end
      drdy = 1'b0;
      chk({tag, "_dvalid_low"}, 32'(dvalid), 32'd0);
      chk({tag, "_xfers"}, 32'(xfers), 32'(exp_x));
      chk({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
   endtask

   // Beat checker: scoreboard on transfers, stability on stalls.
   always @(negedge clk) begin
      if (GlobalReset) begin
         if (prev_stall) begin
            chk("hold_dvalid", 32'(dvalid), 32'd1);
            chk("hold_ch", 32'(ch_out), 32'(prev_ch));
            chk("hold_dout", dout, prev_dout);
         end
         if (dvalid && drdy) begin
            chk("beat_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               beat_t e;
               e = q.pop_front();
               chk("beat_ch", 32'(ch_out), 32'(e.ch));
               chk("beat_dout", dout, e.data);
            end
         end
         prev_stall = dvalid && !drdy;
         prev_ch = ch_out;
         prev_dout = dout;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) mcap[i] = '0;

      // Power-on reset state.
      GlobalReset = 1'b0;
      tick();
      tick();
      chk("rst_dout", dout, 32'd0);
      chk("rst_ch", 32'(ch_out), 32'd0);
      chk("rst_dvalid", 32'(dvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_fcnt", 32'(frame_cnt), 32'd0);
      GlobalReset = 1'b1;
      tick();

      // Reset in the middle of a stalled drain.
      load_frame(32'd100);
      commit('0, '0);
      chk("commit_dvalid", 32'(dvalid), 32'd1);
      chk("commit_busy", 32'(busy), 32'd1);
      drdy = 1'b1;
      repeat (5) tick();
      drdy = 1'b0;
      tick();
      chk("stall_ch5", 32'(ch_out), 32'd5);
      GlobalReset = 1'b0;
      tick();
      GlobalReset = 1'b1;
      q.delete();
      for (int i = 0; i < 32; i++) mcap[i] = '0;
      mfc = 0;
      chk("mrst_dvalid", 32'(dvalid), 32'd0);
      chk("mrst_ch", 32'(ch_out), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
      write_slot(3, 32'h33);
      commit('0, '0);
      wait_drain(0, 32, "mrst");
      mfc++;
      chk("mrst_fcnt_after", 32'(frame_cnt), 32'(mfc));

      // Basic frame with drdy held high.
      load_frame(32'd100);
      commit('0, '0);
      wait_drain(0, 32, "basic");
      mfc++;
      chk("basic_fcnt", 32'(frame_cnt), 32'(mfc));

      // Backpressure with drdy pattern 1,0,0.
      commit('0, '0);
      wait_drain(1, 32, "bp");
      mfc++;
      chk("bp_fcnt", 32'(frame_cnt), 32'(mfc));

      // Slot-31 write in the commit cycle is forwarded.
      load_frame(32'd200);
      commit(32'hFFFF_FFFF, 32'hDEAD);
      wait_drain(0, 32, "fwd");
      mfc++;
      chk("fwd_fcnt", 32'(frame_cnt), 32'(mfc));

      // Back-to-back: next commit on the ch-31 transfer.
      load_frame(32'd300);
      commit('0, '0);
      drdy = 1'b0;
      load_frame(32'd500);
      drdy = 1'b1;
      busy_drop = 1'b0;
      for (int k = 0; k < 64 && ch_out != 5'd31; k++) begin
         if (!busy) busy_drop = 1'b1;
         tick();
      end
      chk("b2b_at_ch31", 32'(ch_out), 32'd31);
      commit('0, '0);
      mfc++;
      chk("b2b_ch0", 32'(ch_out), 32'd0);
      chk("b2b_dvalid", 32'(dvalid), 32'd1);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_dout0", dout, 32'd500);
      chk("b2b_fcnt_mid", 32'(frame_cnt), 32'(mfc));
      chk("b2b_busy_drop", 32'(busy_drop), 32'd0);
      wait_drain(0, 32, "b2b");
      mfc++;
      chk("b2b_fcnt", 32'(frame_cnt), 32'(mfc));
      chk("b2b_ovf", 32'(ovf), 32'd0);

      // Overflow: commit attempt at ch 10 is dropped.
      load_frame(32'd700);
      commit('0, '0);
      drdy = 1'b1;
      for (int k = 0; k < 64 && ch_out != 5'd10; k++) tick();
      chk("ovf_at_ch10", 32'(ch_out), 32'd10);
      enableRegControl = 32'd1 << 20;
      sum_in = 32'hBAD;
      mcap[20] = 32'hBAD;
      srdyi = 1'b1;
      tick();
      srdyi = 1'b0;
      enableRegControl = '0;
      chk("ovf_set", 32'(ovf), 32'd1);
      wait_drain(0, 21, "ovf");
      mfc++;
      chk("ovf_fcnt", 32'(frame_cnt), 32'(mfc));
      repeat (3) tick();
      chk("ovf_sticky", 32'(ovf), 32'd1);
      chk("ovf_idle", 32'(dvalid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
